// File: rtl/io_port_unit.sv
// Input/output port unit: per-channel strobe-captured input FIFOs with an
// edge-triggered datapath read, plus an output register with valid/ack handshake.
module io_port_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int NCH   = 2,
  parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 Clock,
  input  logic                 clear_n,
  input  logic [NCH-1:0]       strobe,
  input  logic [NCH*WIDTH-1:0] input_data,
  input  logic [SEL_W-1:0]     port_sel,
  input  logic                 InPortout,
  output logic [WIDTH-1:0]     BusMuxInInPortout,
  output logic [NCH-1:0]       in_empty,
  output logic [NCH-1:0]       in_full,
  output logic [NCH-1:0]       in_overflow,
  input  logic [WIDTH-1:0]     BusOut,
  input  logic                 OutPortin,
  output logic [WIDTH-1:0]     output_data,
  output logic                 out_valid,
  input  logic                 out_ack,
  output logic                 out_overrun,
  input  logic                 flag_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [NCH-1:0]   strobe_q;
  logic             rd_q;
  logic [WIDTH-1:0] mem    [NCH][DEPTH];
  logic [PTR_W-1:0] wr_ptr [NCH];
  logic [PTR_W-1:0] rd_ptr [NCH];
  logic [CNT_W-1:0] count  [NCH];

  logic [NCH-1:0]   push, pop, accept, drop;
  logic             rd_edge;
  logic [WIDTH-1:0] head;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    rd_edge = InPortout & ~rd_q;
    push    = strobe & ~strobe_q;
    pop     = '0;
    accept  = '0;
    drop    = '0;
    head    = '0;
    for (int c = 0; c < NCH; c++) begin
      // Out-of-range or empty selection leaves head at 0 and pops nothing.
      if (rd_edge && port_sel == SEL_W'(c) && count[c] != '0) begin
        pop[c] = 1'b1;
        head   = mem[c][rd_ptr[c]];
      end
      // A simultaneous pop frees the slot, so a full FIFO still accepts.
      accept[c] = push[c] && (count[c] != FULL_CNT || pop[c]);
      drop[c]   = push[c] && count[c] == FULL_CNT && !pop[c];
    end
  end

  always_comb begin
    in_empty = '0;
    in_full  = '0;
    for (int c = 0; c < NCH; c++) begin
      in_empty[c] = (count[c] == '0);
      in_full[c]  = (count[c] == FULL_CNT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      strobe_q          <= '0;
      rd_q              <= 1'b0;
      in_overflow       <= '0;
      BusMuxInInPortout <= '0;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      strobe_q <= strobe;
      rd_q     <= InPortout;
      if (rd_edge) BusMuxInInPortout <= head;
      for (int c = 0; c < NCH; c++) begin
        if (accept[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])    rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        count[c]       <= count[c] + CNT_W'(accept[c]) - CNT_W'(pop[c]);
        // Set wins over a same-cycle clear.
        in_overflow[c] <= drop[c] | (in_overflow[c] & ~flag_clear);
      end
    end
  end

  // NOTE: FIFO storage is not reset; pointers and counts alone define which
  // entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge Clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (accept[c]) mem[c][wr_ptr[c]] <= input_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      output_data <= '0;
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      out_overrun <= (OutPortin && out_valid && !out_ack) | (out_overrun & ~flag_clear);
      if (OutPortin) begin
        output_data <= BusOut;
        out_valid   <= 1'b1;
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Bench for io_port_unit: read data is checked by a scoreboard monitor,
// flags and the output handshake by direct checks.
module tb_io_port_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;
  localparam int SEL_W = 1;

  logic                 Clock;
  logic                 clear_n;
  logic [NCH-1:0]       strobe;
  logic [NCH*WIDTH-1:0] input_data;
  logic [SEL_W-1:0]     port_sel;
  logic                 InPortout;
  logic [WIDTH-1:0]     BusMuxInInPortout;
  logic [NCH-1:0]       in_empty, in_full, in_overflow;
  logic [WIDTH-1:0]     BusOut;
  logic                 OutPortin;
  logic [WIDTH-1:0]     output_data;
  logic                 out_valid, out_ack, out_overrun, flag_clear;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  io_port_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .Clock(Clock), .clear_n(clear_n), .strobe(strobe), .input_data(input_data),
    .port_sel(port_sel), .InPortout(InPortout), .BusMuxInInPortout(BusMuxInInPortout),
    .in_empty(in_empty), .in_full(in_full), .in_overflow(in_overflow),
    .BusOut(BusOut), .OutPortin(OutPortin), .output_data(output_data),
    .out_valid(out_valid), .out_ack(out_ack), .out_overrun(out_overrun),
    .flag_clear(flag_clear)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read edge sampled at a rising edge must show the queued word
  // on the read register by the following falling edge.
  initial begin
    logic prev_rd;
    logic fire;
    logic [WIDTH-1:0] exp;
    prev_rd = 1'b0;
    forever begin
      @(posedge Clock);
      fire    = clear_n && InPortout && !prev_rd;
      prev_rd = clear_n ? InPortout : 1'b0;
      @(negedge Clock);
      if (fire) begin
        if (exp_q.size() == 0) begin
          check("read_unexpected", 64'(BusMuxInInPortout), 64'hDEAD_0000);
        end else begin
          exp = exp_q.pop_front();
          check("read_data", 64'(BusMuxInInPortout), 64'(exp));
        end
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic push_word(input int ch, input logic [WIDTH-1:0] d);
    input_data[ch*WIDTH +: WIDTH] = d;
    strobe[ch] = 1'b1;
    @(negedge Clock);
    strobe[ch] = 1'b0;
    @(negedge Clock);
  endtask

  task automatic read_word(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    port_sel  = sel;
    InPortout = 1'b1;
    repeat (2) @(negedge Clock);
    InPortout = 1'b0;
    @(negedge Clock);
  endtask

  task automatic out_load(input logic [WIDTH-1:0] d, input logic ack);
    BusOut    = d;
    OutPortin = 1'b1;
    out_ack   = ack;
    @(negedge Clock);
    OutPortin = 1'b0;
    out_ack   = 1'b0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) out_ack = 1'b1; else flag_clear = 1'b1;
    @(negedge Clock);
    out_ack    = 1'b0;
    flag_clear = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0; strobe = '0; input_data = '0; port_sel = '0; InPortout = 1'b0;
    BusOut = '0; OutPortin = 1'b0; out_ack = 1'b0; flag_clear = 1'b0;
    @(negedge Clock);
    check("rst_empty", 64'(in_empty), 64'h3);
    check("rst_read", 64'(BusMuxInInPortout), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    clear_n = 1'b1;
    @(negedge Clock);

    // Single transfer
    push_word(0, 32'hABBA);
    check("ch0_not_empty", 64'(in_empty[0]), 64'h0);
    read_word(0, 32'h0000ABBA);
    check("ch0_empty_after_read", 64'(in_empty[0]), 64'h1);

    // Ordering, overflow, wrap on ch1
    for (int i = 1; i <= 4; i++) push_word(1, WIDTH'(i));
    check("ch1_full", 64'(in_full), 64'h2);
    check("ch1_no_ovf_yet", 64'(in_overflow), 64'h0);
    push_word(1, 32'd5);
    check("ch1_overflow", 64'(in_overflow), 64'h2);
    for (int i = 1; i <= 4; i++) read_word(1, WIDTH'(i));
    read_word(1, 32'd0);
    read_word(1, 32'd0);
    check("ch1_empty", 64'(in_empty), 64'h3);
    check("ovf_sticky", 64'(in_overflow), 64'h2);
    pulse(1);
    check("ovf_cleared", 64'(in_overflow), 64'h0);

    // Push and pop on a full FIFO in the same cycle
    for (int i = 10; i <= 13; i++) push_word(0, WIDTH'(i));
    exp_q.push_back(32'd10);
    input_data[0 +: WIDTH] = 32'd14;
    strobe[0] = 1'b1;
    port_sel  = 1'b0;
    InPortout = 1'b1;
    @(negedge Clock);
    strobe[0] = 1'b0;
    @(negedge Clock);
    InPortout = 1'b0;
    @(negedge Clock);
    check("simul_still_full", 64'(in_full[0]), 64'h1);
    check("simul_no_ovf", 64'(in_overflow[0]), 64'h0);
    for (int i = 11; i <= 14; i++) read_word(0, WIDTH'(i));
    check("simul_drained", 64'(in_empty[0]), 64'h1);

    // Held strobe pushes once; held read pops once
    input_data[WIDTH +: WIDTH] = 32'd77;
    strobe[1] = 1'b1;
    repeat (10) @(negedge Clock);
    strobe[1] = 1'b0;
    @(negedge Clock);
    read_word(1, 32'd77);
    read_word(1, 32'd0);
    push_word(0, 32'd21);
    push_word(0, 32'd22);
    exp_q.push_back(32'd21);
    port_sel  = 1'b0;
    InPortout = 1'b1;
    repeat (5) @(negedge Clock);
    InPortout = 1'b0;
    @(negedge Clock);
    check("held_read_one_left", 64'(in_empty[0]), 64'h0);
    read_word(0, 32'd22);

    // Output handshake
    out_load(32'h1234, 1'b0);
    check("out_valid_set", 64'(out_valid), 64'h1);
    check("out_data_1", 64'(output_data), 64'h1234);
    out_load(32'h5678, 1'b0);
    check("out_data_2", 64'(output_data), 64'h5678);
    check("out_overrun", 64'(out_overrun), 64'h1);
    pulse(0);
    check("out_acked", 64'(out_valid), 64'h0);
    check("overrun_sticky", 64'(out_overrun), 64'h1);
    pulse(1);
    check("overrun_cleared", 64'(out_overrun), 64'h0);
    out_load(32'h9, 1'b0);
    out_load(32'hA, 1'b1);
    check("load_ack_valid", 64'(out_valid), 64'h1);
    check("load_ack_data", 64'(output_data), 64'hA);
    check("load_ack_no_overrun", 64'(out_overrun), 64'h0);

    // Asynchronous reset mid-operation
    push_word(0, 32'd31);
    push_word(0, 32'd32);
    check("pre_rst_valid", 64'(out_valid), 64'h1);
    check("pre_rst_read", 64'(BusMuxInInPortout), 64'd22);
    #1 clear_n = 1'b0;
    #1;
    check("mid_rst_read", 64'(BusMuxInInPortout), 64'h0);
    check("mid_rst_out", 64'(output_data), 64'h0);
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_empty", 64'(in_empty), 64'h3);
    check("mid_rst_full", 64'(in_full), 64'h0);
    #2 clear_n = 1'b1;
    @(negedge Clock);
    read_word(0, 32'd0);

    repeat (2) @(negedge Clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
